// File: rtl/block_pack_queue_pkg.sv
// block_pack_queue shared definitions.
// Exports the enable/disable macros, default sizes and min_u.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package block_pack_queue_pkg;

    localparam int ELMS_D     = 8;
    localparam int DATA_D     = 8;
    localparam int IN_ELMS_D  = 4;
    localparam int OUT_ELMS_D = 4;

    function automatic int min_u(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/block_pack_queue_if.sv
// Element stream bundle between producer/consumer and the queue.
// master: drives flush/in_*/out_cnt; slave: drives in_ready/out_*/occupancy.
interface block_pack_queue_if #(
    parameter int ELMS     = 8,
    parameter int DATA     = 8,
    parameter int IN_ELMS  = 4,
    parameter int OUT_ELMS = 4,
    localparam int CNT  = $clog2(ELMS + 1),
    localparam int ICNT = $clog2(IN_ELMS + 1),
    localparam int OCNT = $clog2(OUT_ELMS + 1)
);
    logic                              flush;
    logic                              in_valid;
    logic [ICNT-1:0]                   in_cnt;
    logic [IN_ELMS-1:0][DATA-1:0]      in_data;
    logic                              in_ready;
    logic [OUT_ELMS-1:0][DATA-1:0]     out_data;
    logic [OCNT-1:0]                   out_avail;
    logic [OCNT-1:0]                   out_cnt;
    logic [CNT-1:0]                    occupancy;

    modport master (
        output flush, in_valid, in_cnt, in_data, out_cnt,
        input  in_ready, out_data, out_avail, occupancy
    );

    modport slave (
        input  flush, in_valid, in_cnt, in_data, out_cnt,
        output in_ready, out_data, out_avail, occupancy
    );
endinterface

// File: rtl/block_shift.sv
// Element-granular shifter/rotator over a packed element array.
// Ports: in (elements), shamt (element count), out (shifted elements).
module block_shift #(
    parameter bit ROTATE   = 1'b0,
    parameter bit TO_RIGHT = 1'b1,
    parameter int ELMS     = 8,
    parameter int DATA     = 8,
    parameter int CNT      = $clog2(ELMS + 1)
) (
    input  logic [ELMS-1:0][DATA-1:0] in,
    input  logic [CNT-1:0]            shamt,
    output logic [ELMS-1:0][DATA-1:0] out
);
    // TO_RIGHT moves elements toward index 0.
    always_comb begin
        int src;
        out = '0;
        src = 0;
        for (int i = 0; i < ELMS; i++) begin
            if (TO_RIGHT) src = i + int'(shamt);
            else          src = i - int'(shamt);
            if (ROTATE) src = ((src % ELMS) + ELMS) % ELMS;
            if (src >= 0 && src < ELMS) out[i] = in[src];
        end
    end
endmodule

// File: rtl/block_pack_queue.sv
// Collapsing element queue: variable enqueue, variable drain, entry 0 oldest.
// Ports: clk, reset_ (async active-low), bus (slave side of the stream bundle).
module block_pack_queue
    import block_pack_queue_pkg::*;
#(
    parameter int ELMS     = ELMS_D,
    parameter int DATA     = DATA_D,
    parameter int IN_ELMS  = IN_ELMS_D,
    parameter int OUT_ELMS = OUT_ELMS_D,
    localparam int CNT  = $clog2(ELMS + 1),
    localparam int OCNT = $clog2(OUT_ELMS + 1)
) (
    input logic              clk,
    input logic              reset_,
    block_pack_queue_if.slave bus
);
    logic [CNT-1:0]            count;
    logic [ELMS-1:0][DATA-1:0] store;
    logic [ELMS-1:0][DATA-1:0] drained;
    logic [ELMS-1:0][DATA-1:0] ins;
    logic [ELMS-1:0][DATA-1:0] placed;
    logic [CNT-1:0]            deq;
    logic [CNT-1:0]            enq;
    logic [CNT-1:0]            base;
    logic [OCNT-1:0]           avail;
    logic                      ready;

    // Credit from registered count only; dequeue in the same cycle does not help.
    assign ready = (ELMS - int'(count)) >= IN_ELMS;
    assign avail = OCNT'(min_u(int'(count), OUT_ELMS));
    assign deq   = CNT'(min_u(int'(bus.out_cnt), int'(avail)));
    assign enq   = (bus.in_valid && ready)
                 ? CNT'(min_u(int'(bus.in_cnt), IN_ELMS)) : '0;
    assign base  = count - deq;

    // Only the first enq input elements may reach storage.
    always_comb begin
        ins = '0;
        for (int i = 0; i < IN_ELMS; i++)
            if (i < int'(enq)) ins[i] = bus.in_data[i];
    end

    block_shift #(
        .ROTATE(`DISABLE), .TO_RIGHT(`ENABLE),
        .ELMS(ELMS), .DATA(DATA), .CNT(CNT)
    ) u_drain (
        .in(store), .shamt(deq), .out(drained)
    );

    block_shift #(
        .ROTATE(`DISABLE), .TO_RIGHT(`DISABLE),
        .ELMS(ELMS), .DATA(DATA), .CNT(CNT)
    ) u_insert (
        .in(ins), .shamt(base), .out(placed)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            count <= '0;
            store <= '0;
        end else if (bus.flush) begin
            count <= '0;
            store <= '0;
        end else begin
            count <= base + enq;
            store <= drained | placed;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < OUT_ELMS; i++) bus.out_data[i] = store[i];
    end

    assign bus.in_ready  = ready;
    assign bus.out_avail = avail;
    assign bus.occupancy = count;
endmodule

// File: tb/tb_block_pack_queue.sv
// Self-checking bench for block_pack_queue against a queue-based model.
// Directed vectors plus a short pseudo-random tail.
module tb_block_pack_queue;
    logic clk = 0;
    logic reset_ = 0;
    int checks = 0;
    int passed = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    block_pack_queue_if bus ();

    block_pack_queue dut (.clk(clk), .reset_(reset_), .bus(bus.slave));

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model: a plain FIFO of bytes; state advances on each rising edge.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            q.delete();
        end else if (bus.flush) begin
            q.delete();
        end else begin
            int sz, dq, nq;
            bit rdy;
            sz  = q.size();
            rdy = (8 - sz) >= 4;
            dq  = mn(int'(bus.out_cnt), mn(sz, 4));
            for (int i = 0; i < dq; i++) void'(q.pop_front());
            nq = (bus.in_valid && rdy) ? mn(int'(bus.in_cnt), 4) : 0;
            for (int i = 0; i < nq; i++) q.push_back(bus.in_data[i]);
        end
    end

    // Cycle compare against model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [31:0] ed;
        ed = '0;
        for (int i = 0; i < 4; i++)
            if (i < q.size()) ed[i*8 +: 8] = q[i];
        chk("cyc_occ", 64'(bus.occupancy), 64'(q.size()));
        chk("cyc_avail", 64'(bus.out_avail), 64'(mn(q.size(), 4)));
        chk("cyc_data", 64'(bus.out_data), 64'(ed));
        chk("cyc_ready", 64'(bus.in_ready), 64'((8 - q.size()) >= 4));
    end

    // Apply inputs for one edge, then return 2 time units after it.
    task automatic cyc(input logic v, input logic [2:0] ic,
                       input logic [31:0] d, input logic [2:0] oc,
                       input logic fl);
        bus.in_valid = v;
        bus.in_cnt   = ic;
        bus.in_data  = d;
        bus.out_cnt  = oc;
        bus.flush    = fl;
        @(posedge clk);
        #2;
        bus.in_valid = 0;
        bus.in_cnt   = 0;
        bus.in_data  = '0;
        bus.out_cnt  = 0;
        bus.flush    = 0;
    endtask

    task automatic lit(input string n, input int occ, input int av,
                       input logic [31:0] d, input logic rdy);
        chk({n, "_occ"}, 64'(bus.occupancy), 64'(occ));
        chk({n, "_avail"}, 64'(bus.out_avail), 64'(av));
        chk({n, "_data"}, 64'(bus.out_data), 64'(d));
        chk({n, "_ready"}, 64'(bus.in_ready), 64'(rdy));
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_cnt   = 0;
        bus.in_data  = '0;
        bus.out_cnt  = 0;
        bus.flush    = 0;
        repeat (2) @(posedge clk);
        #2;
        lit("reset", 0, 0, 32'h0, 1);
        reset_ = 1;

        cyc(1, 3, 32'hEE131211, 0, 0);
        lit("enq3", 3, 3, 32'h00131211, 1);

        cyc(1, 4, 32'h24232221, 2, 0);
        lit("enqdeq", 5, 4, 32'h23222113, 0);

        cyc(1, 2, 32'hAAAAAAAA, 0, 0);
        lit("notready", 5, 4, 32'h23222113, 0);
        cyc(0, 0, 32'h0, 1, 0);
        lit("deq1", 4, 4, 32'h24232221, 1);

        cyc(0, 0, 32'h0, 3, 0);
        lit("deq3", 1, 1, 32'h00000024, 1);
        cyc(0, 0, 32'h0, 4, 0);
        lit("overdeq", 0, 0, 32'h0, 1);

        cyc(1, 2, 32'hFFFF5251, 0, 0);
        lit("enq2", 2, 2, 32'h00005251, 1);
        cyc(1, 0, 32'hAAAAAAAA, 0, 0);
        lit("cnt0", 2, 2, 32'h00005251, 1);

        cyc(1, 4, 32'h64636261, 0, 0);
        lit("six", 6, 4, 32'h62615251, 0);
        cyc(1, 4, 32'h77777777, 2, 1);
        lit("flush", 0, 0, 32'h0, 1);

        cyc(1, 4, 32'h84838281, 0, 0);
        cyc(1, 7, 32'h88878685, 0, 0);
        lit("full", 8, 4, 32'h84838281, 0);
        cyc(0, 0, 32'h0, 4, 0);
        lit("half", 4, 4, 32'h88878685, 1);
        cyc(1, 1, 32'h00000091, 0, 0);
        lit("five", 5, 4, 32'h88878685, 0);

        // Asynchronous reset mid-cycle with five entries held.
        reset_ = 0;
        #1;
        lit("async_rst", 0, 0, 32'h0, 1);
        @(posedge clk);
        #2;
        reset_ = 1;

        for (int k = 0; k < 60; k++)
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)),
                $urandom, 3'($urandom_range(0, 5)),
                1'($urandom_range(0, 15) == 0));

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
